// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// Sequencing controller for the countdown timer datapath. It owns the
// IDLE/RUN/PAUSED/DONE state machine, the 1 s prescaler and the mm:ss
// down-counter. Every output is a register, so an event sampled on edge n
// becomes visible just after edge n.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per 1 s tick (minimum 2)
//   MAX_MIN        upper clamp applied to loaded minutes
//
// Ports
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   start_p  in   one-cycle start pulse (already edge-detected)
//   pause_p  in   one-cycle pause/resume pulse
//   stop_p   in   one-cycle stop pulse
//   min_in   in   requested minutes (binary), sampled only on accepted start
//   sec_in   in   requested seconds (binary), sampled only on accepted start
//   min_out  out  current minutes
//   sec_out  out  current seconds (never above 59)
//   state    out  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   tick     out  one-cycle pulse on each applied 1 s decrement
//   done     out  high while in DONE
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int MAX_MIN       = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       stop_p,
  input  logic [6:0] min_in,
  input  logic [6:0] sec_in,
  output logic [6:0] min_out,
  output logic [6:0] sec_out,
  output logic [1:0] state,
  output logic       tick,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    MAX_MIN_V  = 7'(MAX_MIN);
  localparam logic [6:0]    MAX_SEC_V  = 7'd59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [6:0]    min_reg;
  logic [6:0]    sec_reg;
  logic          tick_reg;
  logic          done_reg;

  // Clamped load value and whether it would be an empty (00:00) load.
  logic [6:0] load_min;
  logic [6:0] load_sec;
  logic       load_zero;

  // Value the counter takes on the next applied decrement.
  logic [6:0] dec_min;
  logic [6:0] dec_sec;
  logic       dec_zero;
  logic       presc_last;

  always_comb begin
    load_min  = (min_in > MAX_MIN_V) ? MAX_MIN_V : min_in;
    load_sec  = (sec_in > MAX_SEC_V) ? MAX_SEC_V : sec_in;
    load_zero = (load_min == 7'd0) && (load_sec == 7'd0);
  end

  always_comb begin
    dec_min = min_reg;
    dec_sec = sec_reg;
    if (sec_reg != 7'd0) begin
      dec_sec = sec_reg - 7'd1;
    end else begin
      // Borrow from minutes. Never reached with 00:00 in RUN because a
      // zero load is refused and 00:00 moves the machine to DONE.
      dec_sec = MAX_SEC_V;
      dec_min = min_reg - 7'd1;
    end
    dec_zero   = (dec_min == 7'd0) && (dec_sec == 7'd0);
    presc_last = (presc_reg == PRESC_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      tick_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      // tick is a single-cycle pulse; only the terminal-count branch raises it.
      tick_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // pause_p and stop_p are meaningless here.
          if (start_p && !load_zero) begin
            min_reg   <= load_min;
            sec_reg   <= load_sec;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop_p) begin
            min_reg   <= '0;
            sec_reg   <= '0;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (pause_p) begin
            // Prescaler holds even at its terminal count, so a tick that
            // was due now is delivered on the first RUN cycle after resume.
            state_reg <= ST_PAUSED;
          end else if (presc_last) begin
            presc_reg <= '0;
            tick_reg  <= 1'b1;
            min_reg   <= dec_min;
            sec_reg   <= dec_sec;
            if (dec_zero) begin
              // DONE is entered on the same edge that writes 00:00.
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end else begin
            presc_reg <= presc_reg + PW'(1);
          end
        end

        ST_PAUSED: begin
          if (stop_p) begin
            min_reg   <= '0;
            sec_reg   <= '0;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (start_p || pause_p) begin
            // Resume; prescaler continues from its held value.
            state_reg <= ST_RUN;
          end
        end

        ST_DONE: begin
          if (stop_p) begin
            min_reg   <= '0;
            sec_reg   <= '0;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (start_p && !load_zero) begin
            // Restart behaves exactly like a load from IDLE.
            min_reg   <= load_min;
            sec_reg   <= load_sec;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign min_out = min_reg;
  assign sec_out = sec_reg;
  assign state   = state_reg;
  assign tick    = tick_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//
// Directed bench for timer_ctrl with TICKS_PER_SEC=4. A table of per-cycle
// input vectors with hand-computed expected outputs is applied first, then a
// few hand-written sequences cover pause/resume timing, stop priority and
// mid-run reset.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PAU  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_p = 1'b0;
  logic       pause_p = 1'b0;
  logic       stop_p = 1'b0;
  logic [6:0] min_in = '0;
  logic [6:0] sec_in = '0;
  logic [6:0] min_out;
  logic [6:0] sec_out;
  logic [1:0] state;
  logic       tick;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  timer_ctrl #(
    .TICKS_PER_SEC(4),
    .MAX_MIN      (99)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start_p(start_p),
    .pause_p(pause_p),
    .stop_p (stop_p),
    .min_in (min_in),
    .sec_in (sec_in),
    .min_out(min_out),
    .sec_out(sec_out),
    .state  (state),
    .tick   (tick),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic       st;
    logic       pa;
    logic       sp;
    logic [6:0] mi;
    logic [6:0] si;
    logic [6:0] em;
    logic [6:0] es;
    logic [1:0] est;
    logic       et;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic st, input logic pa, input logic sp,
                     input logic [6:0] mi, input logic [6:0] si,
                     input logic [6:0] em, input logic [6:0] es, input logic [1:0] est,
                     input logic et, input logic ed);
    vec_t v;
    v.nm = nm; v.st = st; v.pa = pa; v.sp = sp; v.mi = mi; v.si = si;
    v.em = em; v.es = es; v.est = est; v.et = et; v.ed = ed;
    vecs.push_back(v);
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic rs, input logic st, input logic pa, input logic sp,
                      input logic [6:0] mi, input logic [6:0] si);
    reset = rs; start_p = st; pause_p = pa; stop_p = sp; min_in = mi; sec_in = si;
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string nm, input string f, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, f, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [6:0] em, input logic [6:0] es,
                       input logic [1:0] est, input logic et, input logic ed);
    $display("step %-12s state=%0d %02d:%02d tick=%0d done=%0d", nm, state,
             min_out, sec_out, tick, done);
    cmp(nm, "state", int'(state), int'(est));
    cmp(nm, "min", int'(min_out), int'(em));
    cmp(nm, "sec", int'(sec_out), int'(es));
    cmp(nm, "tick", int'(tick), int'(et));
    cmp(nm, "done", int'(done), int'(ed));
  endtask

  // Idle cycle with an expected result.
  task automatic idle(input string nm, input logic [6:0] em, input logic [6:0] es,
                      input logic [1:0] est, input logic et, input logic ed);
    step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check(nm, em, es, est, et, ed);
  endtask

  initial begin
    // Table: load 0:03, count down to DONE, restart with 1:00 for a borrow,
    // stop+pause priority, idle-state inputs, clamped load, start ignored in RUN.
    //   name        st pa sp  mi      si      em      es      state   tk dn
    add("load3",     1, 0, 0, 7'd0,   7'd3,   7'd0,   7'd3,   S_RUN,  0, 0);
    add("p1",        0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd3,   S_RUN,  0, 0);
    add("p2",        0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd3,   S_RUN,  0, 0);
    add("p3",        0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd3,   S_RUN,  0, 0);
    add("tick2",     0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd2,   S_RUN,  1, 0);
    add("p1b",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd2,   S_RUN,  0, 0);
    add("p2b",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd2,   S_RUN,  0, 0);
    add("p3b",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd2,   S_RUN,  0, 0);
    add("tick1",     0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd1,   S_RUN,  1, 0);
    add("p1c",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd1,   S_RUN,  0, 0);
    add("p2c",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd1,   S_RUN,  0, 0);
    add("p3c",       0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd1,   S_RUN,  0, 0);
    add("tick0",     0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd0,   S_DONE, 1, 1);
    add("donehold",  0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd0,   S_DONE, 0, 1);
    add("donepause", 0, 1, 0, 7'd0,   7'd0,   7'd0,   7'd0,   S_DONE, 0, 1);
    add("donezero",  1, 0, 0, 7'd0,   7'd0,   7'd0,   7'd0,   S_DONE, 0, 1);
    add("load100",   1, 0, 0, 7'd1,   7'd0,   7'd1,   7'd0,   S_RUN,  0, 0);
    add("q1",        0, 0, 0, 7'd0,   7'd0,   7'd1,   7'd0,   S_RUN,  0, 0);
    add("q2",        0, 0, 0, 7'd0,   7'd0,   7'd1,   7'd0,   S_RUN,  0, 0);
    add("q3",        0, 0, 0, 7'd0,   7'd0,   7'd1,   7'd0,   S_RUN,  0, 0);
    add("borrow",    0, 0, 0, 7'd0,   7'd0,   7'd0,   7'd59,  S_RUN,  1, 0);
    add("stoppause", 0, 1, 1, 7'd0,   7'd0,   7'd0,   7'd0,   S_IDLE, 0, 0);
    add("idlepause", 0, 1, 1, 7'd5,   7'd5,   7'd0,   7'd0,   S_IDLE, 0, 0);
    add("clamp",     1, 0, 0, 7'd120, 7'd75,  7'd99,  7'd59,  S_RUN,  0, 0);
    add("runstart",  1, 0, 0, 7'd1,   7'd1,   7'd99,  7'd59,  S_RUN,  0, 0);

    // Reset state, held for two edges with a start pulse that must be ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 7'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 7'd5);
    check("reset", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].st, vecs[i].pa, vecs[i].sp, vecs[i].mi, vecs[i].si);
      check(vecs[i].nm, vecs[i].em, vecs[i].es, vecs[i].est, vecs[i].et, vecs[i].ed);
    end

    // Pause with prescaler at 2, hold 10 cycles, resume with pause_p.
    idle("pre2", 7'd99, 7'd59, S_RUN, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    check("pause2", 7'd99, 7'd59, S_PAU, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle("held", 7'd99, 7'd59, S_PAU, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    check("resume2", 7'd99, 7'd59, S_RUN, 1'b0, 1'b0);
    idle("pre3", 7'd99, 7'd59, S_RUN, 1'b0, 1'b0);
    idle("tickres", 7'd99, 7'd58, S_RUN, 1'b1, 1'b0);

    // Pause exactly at terminal count; resume with start_p (load ignored).
    idle("t1", 7'd99, 7'd58, S_RUN, 1'b0, 1'b0);
    idle("t2", 7'd99, 7'd58, S_RUN, 1'b0, 1'b0);
    idle("t3", 7'd99, 7'd58, S_RUN, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    check("pauseterm", 7'd99, 7'd58, S_PAU, 1'b0, 1'b0);
    idle("heldterm", 7'd99, 7'd58, S_PAU, 1'b0, 1'b0);
    idle("heldterm", 7'd99, 7'd58, S_PAU, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 7'd1);
    check("startres", 7'd99, 7'd58, S_RUN, 1'b0, 1'b0);
    idle("tickterm", 7'd99, 7'd57, S_RUN, 1'b1, 1'b0);

    // Stop while PAUSED.
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    check("pauseC", 7'd99, 7'd57, S_PAU, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
    check("pausestop", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);

    // Run 0:01 into DONE, then start+stop together: stop wins.
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd1);
    check("load1", 7'd0, 7'd1, S_RUN, 1'b0, 1'b0);
    idle("d1", 7'd0, 7'd1, S_RUN, 1'b0, 1'b0);
    idle("d2", 7'd0, 7'd1, S_RUN, 1'b0, 1'b0);
    idle("d3", 7'd0, 7'd1, S_RUN, 1'b0, 1'b0);
    idle("dtick", 7'd0, 7'd0, S_DONE, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 7'd5, 7'd5);
    check("donestop", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);

    // Mid-run reset on the cycle a tick would have fired.
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd2);
    check("load2", 7'd0, 7'd2, S_RUN, 1'b0, 1'b0);
    idle("e1", 7'd0, 7'd2, S_RUN, 1'b0, 1'b0);
    idle("e2", 7'd0, 7'd2, S_RUN, 1'b0, 1'b0);
    idle("e3", 7'd0, 7'd2, S_RUN, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 7'd3, 7'd3);
    check("midreset", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    check("zeroload", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd75);
    check("secclamp", 7'd0, 7'd59, S_RUN, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
    check("runstop", 7'd0, 7'd0, S_IDLE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
